// File: rtl/mc_mem_responder.sv
// Memory-side responder for the multicycle CPU bus: word RAM with programmable wait states.
// Optional alignment checking is enabled with `define MEM_ALIGN_CHECK_EN.
module mc_mem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mreq,
    input  logic        wmem,
    input  logic [31:0] madr,
    input  logic [31:0] tomem,
    output logic [31:0] frommem,
    output logic        mready,
    output logic        merr
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [3:0]  WS_INIT  = 4'(WAIT_STATES);
    localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

    function automatic logic is_misaligned(input logic [31:0] adr);
`ifdef MEM_ALIGN_CHECK_EN
        return (adr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    state_t                 r_state;
    state_t                 w_next_state;
    logic [3:0]             r_cnt;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [31:0]            r_data;
    logic                   r_wmem;
    logic                   r_misalign;
    logic [31:0]            r_frommem;
    logic                   r_mready;
    logic                   r_merr;
    logic [31:0]            r_mem [0:(2**ADDR_BITS)-1];

    logic                   w_accept;
    logic                   w_access;
    logic [ADDR_BITS-1:0]   w_acc_idx;
    logic [31:0]            w_acc_data;
    logic                   w_acc_wmem;
    logic                   w_acc_mis;
    logic                   w_unused_adr;

    assign w_unused_adr = ^{madr[31:ADDR_BITS+2], madr[1:0]};

    // The acknowledge cycle still sees the held mreq, so it must not re-capture it.
    assign w_accept = (r_state == S_IDLE) && mreq && !r_mready;

    // Next-state decode and selection of the access that commits on the edge entering ACK.
    always_comb begin
        w_next_state = r_state;
        w_access     = 1'b0;
        w_acc_idx    = r_idx;
        w_acc_data   = r_data;
        w_acc_wmem   = r_wmem;
        w_acc_mis    = r_misalign;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (WS_INIT == 4'd0) begin
                        // No wait states: the access uses the live bus values.
                        w_next_state = S_ACK;
                        w_access     = 1'b1;
                        w_acc_idx    = madr[ADDR_BITS+1:2];
                        w_acc_data   = tomem;
                        w_acc_wmem   = wmem;
                        w_acc_mis    = is_misaligned(madr);
                    end else begin
                        w_next_state = S_BUSY;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_BUSY: begin
                if (r_cnt <= 4'd1) begin
                    w_next_state = S_ACK;
                    w_access     = 1'b1;
                end else begin
                    w_next_state = S_BUSY;
                end
            end
            S_ACK:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM, request capture, wait counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_data     <= 32'h0;
            r_wmem     <= 1'b0;
            r_misalign <= 1'b0;
            r_frommem  <= 32'h0;
            r_mready   <= 1'b0;
            r_merr     <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_mready <= (r_state == S_ACK);
            r_merr   <= (r_state == S_ACK) && r_misalign;
            if (w_accept) begin
                r_idx      <= madr[ADDR_BITS+1:2];
                r_data     <= tomem;
                r_wmem     <= wmem;
                r_misalign <= is_misaligned(madr);
                r_cnt      <= WS_INIT;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_access && !w_acc_wmem) begin
                r_frommem <= w_acc_mis ? BAD_DATA : r_mem[w_acc_idx];
            end else begin
                r_frommem <= r_frommem;
            end
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (!reset && w_access && w_acc_wmem && !w_acc_mis) begin
            r_mem[w_acc_idx] <= w_acc_data;
        end
    end

    assign frommem = r_frommem;
    assign mready  = r_mready;
    assign merr    = r_merr;
endmodule
